ex_muldiv: RTL and testbench

- Multi-cycle RV32M execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits beside the single-cycle execute stage. Receives op1/op2 from the ID/EX register and writes the result back via rd_addr/rd_data/rd_wen.
- Stalls the pipeline through the hold-to-ctrl path while iterating.
- Uses a radix-2 shift-add multiplier and a restoring divider, sharing one XLEN-iteration datapath. Word width is parametrised.

---
 rtl/ex_muldiv.sv | 174 +++++++++++++++++
 tb/tb_ex_muldiv.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M execute unit: radix-2 shift-add multiplier and restoring
// divider sharing one XLEN-iteration datapath, with pipeline hold and writeback.
module ex_muldiv #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_start,
   input  logic [2:0]      i_op_sel,
   input  logic [XLEN-1:0] i_op1,
   input  logic [XLEN-1:0] i_op2,
   input  logic [4:0]      i_rd_addr2ex,
   input  logic            i_flush,
   output logic            o_hold2ctrl,
   output logic [4:0]      o_rd_addr,
   output logic [XLEN-1:0] o_rd_data,
   output logic            o_rd_wen2reg,
   output logic            o_busy
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [2:0]        r_op;
   logic              r_neg;
   logic [4:0]        r_rdLatch;
   logic [XLEN-1:0]   r_acc;
   logic [XLEN-1:0]   r_mq;
   logic [XLEN-1:0]   r_opd;
   logic [4:0]        r_rd_addr;
   logic [XLEN-1:0]   r_rd_data;
   logic              r_wen;

   logic              w_signA;
   logic              w_signB;
   logic              w_neg;
   logic [XLEN-1:0]   w_absA;
   logic [XLEN-1:0]   w_absB;
   logic              w_divZero;
   logic              w_ovf;
   logic              w_special;
   logic [XLEN-1:0]   w_specVal;
   logic [XLEN:0]     w_addSum;
   logic [XLEN:0]     w_remSh;
   logic [XLEN:0]     w_diff;
   logic [XLEN-1:0]   w_accNext;
   logic [XLEN-1:0]   w_mqNext;
   logic [2*XLEN-1:0] w_prod;
   logic [2*XLEN-1:0] w_prodS;
   logic [XLEN-1:0]   w_quotS;
   logic [XLEN-1:0]   w_remS;
   logic [XLEN-1:0]   w_result;

   // Signed variants: MULH, MULHSU (op1 only), DIV, REM; MUL uses unsigned magnitudes.
   assign w_signA = ((i_op_sel == 3'd1) || (i_op_sel == 3'd2) ||
                     (i_op_sel == 3'd4) || (i_op_sel == 3'd6)) && i_op1[XLEN-1];
   assign w_signB = ((i_op_sel == 3'd1) || (i_op_sel == 3'd4) ||
                     (i_op_sel == 3'd6)) && i_op2[XLEN-1];
   assign w_absA  = w_signA ? (~i_op1 + 1'b1) : i_op1;
   assign w_absB  = w_signB ? (~i_op2 + 1'b1) : i_op2;
   assign w_neg   = (i_op_sel == 3'd6) ? w_signA : (w_signA ^ w_signB);

   assign w_divZero = i_op_sel[2] && (i_op2 == '0);
   assign w_ovf     = i_op_sel[2] && !i_op_sel[0] &&
                      (i_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_op2 == '1);
   assign w_special = w_divZero || w_ovf;

   always_comb begin
      w_specVal = '0;
      if (w_divZero)
         w_specVal = i_op_sel[1] ? i_op1 : '1;
      else
         w_specVal = i_op_sel[1] ? '0 : i_op1;
   end

   assign w_addSum = {1'b0, r_acc} + {1'b0, (r_mq[0] ? r_opd : '0)};
   assign w_remSh  = {r_acc, r_mq[XLEN-1]};
   assign w_diff   = w_remSh - {1'b0, r_opd};

   always_comb begin
      w_accNext = w_addSum[XLEN:1];
      w_mqNext  = {w_addSum[0], r_mq[XLEN-1:1]};
      if (r_op[2]) begin
         if (!w_diff[XLEN]) begin
            w_accNext = w_diff[XLEN-1:0];
            w_mqNext  = {r_mq[XLEN-2:0], 1'b1};
         end else begin
            w_accNext = w_remSh[XLEN-1:0];
            w_mqNext  = {r_mq[XLEN-2:0], 1'b0};
         end
      end
   end

   // Result is formed from the final iteration's next-state so it can be registered into DONE.
   assign w_prod  = {w_accNext, w_mqNext};
   assign w_prodS = r_neg ? (~w_prod + 1'b1) : w_prod;
   assign w_quotS = r_neg ? (~w_mqNext + 1'b1) : w_mqNext;
   assign w_remS  = r_neg ? (~w_accNext + 1'b1) : w_accNext;

   always_comb begin
      w_result = w_remS;
      case (r_op)
         3'd0:             w_result = w_prodS[XLEN-1:0];
         3'd1, 3'd2, 3'd3: w_result = w_prodS[2*XLEN-1:XLEN];
         3'd4, 3'd5:       w_result = w_quotS;
         default:          w_result = w_remS;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_op      <= '0;
         r_neg     <= 1'b0;
         r_rdLatch <= '0;
         r_acc     <= '0;
         r_mq      <= '0;
         r_opd     <= '0;
         r_rd_addr <= '0;
         r_rd_data <= '0;
         r_wen     <= 1'b0;
      end else begin
         r_wen <= 1'b0;
         if (i_flush) begin
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (i_start) begin
                     r_op      <= i_op_sel;
                     r_neg     <= w_neg;
                     r_rdLatch <= i_rd_addr2ex;
                     r_acc     <= '0;
                     r_cnt     <= '0;
                     r_mq      <= i_op_sel[2] ? w_absA : w_absB;
                     r_opd     <= i_op_sel[2] ? w_absB : w_absA;
                     if (w_special) begin
                        r_state   <= S_DONE;
                        r_wen     <= 1'b1;
                        r_rd_data <= w_specVal;
                        r_rd_addr <= i_rd_addr2ex;
                     end else begin
                        r_state <= S_CALC;
                     end
                  end
               end
               S_CALC: begin
                  r_acc <= w_accNext;
                  r_mq  <= w_mqNext;
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == CNT_W'(XLEN-1)) begin
                     r_state   <= S_DONE;
                     r_wen     <= 1'b1;
                     r_rd_data <= w_result;
                     r_rd_addr <= r_rdLatch;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign o_hold2ctrl  = ((r_state == S_IDLE) && i_start && !i_flush && !w_special) ||
                         (r_state == S_CALC);
   assign o_rd_addr    = r_rd_addr;
   assign o_rd_data    = r_rd_data;
   assign o_rd_wen2reg = r_wen && !i_flush;
   assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv: multiply/divide results, latency,
// hold window, special cases, flush and asynchronous reset behaviour.
module tb_ex_muldiv;

   logic        clk;
   logic        rst_n;
   logic        i_start;
   logic [2:0]  i_op_sel;
   logic [31:0] i_op1;
   logic [31:0] i_op2;
   logic [4:0]  i_rd_addr2ex;
   logic        i_flush;
   logic        o_hold2ctrl;
   logic [4:0]  o_rd_addr;
   logic [31:0] o_rd_data;
   logic        o_rd_wen2reg;
   logic        o_busy;

   int nAsserts = 0;
   int nFails   = 0;

   ex_muldiv #(.XLEN(32), .CNT_W(6)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_start      (i_start),
      .i_op_sel     (i_op_sel),
      .i_op1        (i_op1),
      .i_op2        (i_op2),
      .i_rd_addr2ex (i_rd_addr2ex),
      .i_flush      (i_flush),
      .o_hold2ctrl  (o_hold2ctrl),
      .o_rd_addr    (o_rd_addr),
      .o_rd_data    (o_rd_data),
      .o_rd_wen2reg (o_rd_wen2reg),
      .o_busy       (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: every check in the bench funnels through here.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nAsserts++;
      assert (observed === expected)
      else begin
         nFails++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Presents one request at a negedge; caller decides how long start stays high.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd);
      @(negedge clk);
      i_op_sel     = op;
      i_op1        = a;
      i_op2        = b;
      i_rd_addr2ex = rd;
      i_start      = 1'b1;
   endtask

   // Issues one operation, measures writeback latency and hold window, checks result and pulse width.
   task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] expData, input int expLat);
      int  lat;
      int  holdCnt;
      bit  found;
      applyStimulus(op, a, b, rd);
      #1;
      holdCnt = o_hold2ctrl ? 1 : 0;
      @(posedge clk);
      #1 i_start = 1'b0;
      lat   = 0;
      found = 0;
      for (int c = 1; c <= 60 && !found; c++) begin
         @(negedge clk);
         lat = c;
         if (o_rd_wen2reg) found = 1;
         else if (o_hold2ctrl) holdCnt++;
      end
      checkOutput({tag, "_lat"}, lat, expLat);
      checkOutput({tag, "_data"}, o_rd_data, expData);
      checkOutput({tag, "_addr"}, {27'd0, o_rd_addr}, {27'd0, rd});
      checkOutput({tag, "_hold"}, holdCnt, (expLat > 1) ? 33 : 0);
      checkOutput({tag, "_holdDone"}, {31'd0, o_hold2ctrl}, 32'd0);
      @(negedge clk);
      checkOutput({tag, "_wenPulse"}, {31'd0, o_rd_wen2reg}, 32'd0);
      checkOutput({tag, "_idle"}, {31'd0, o_busy}, 32'd0);
   endtask

   initial begin
      bit sawWen;
      rst_n        = 1'b0;
      i_start      = 1'b0;
      i_flush      = 1'b0;
      i_op_sel     = 3'd0;
      i_op1        = '0;
      i_op2        = '0;
      i_rd_addr2ex = '0;
      #12;
      checkOutput("rst_data", o_rd_data, 32'd0);
      checkOutput("rst_addr", {27'd0, o_rd_addr}, 32'd0);
      checkOutput("rst_wen", {31'd0, o_rd_wen2reg}, 32'd0);
      checkOutput("rst_busy", {31'd0, o_busy}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] multiply group");
      runOp("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33);
      runOp("mulh",   3'd1, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 33);
      runOp("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 33);
      runOp("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, 33);

      $display("[TB] divide group");
      runOp("div",  3'd4, 32'hFFFFFFF9, 32'd2, 5'd9,  32'hFFFFFFFD, 33);
      runOp("rem",  3'd6, 32'hFFFFFFF9, 32'd2, 5'd10, 32'hFFFFFFFF, 33);
      runOp("divu", 3'd5, 32'd100,      32'd7, 5'd11, 32'd14,       33);
      runOp("remu", 3'd7, 32'd100,      32'd7, 5'd12, 32'd2,        33);

      $display("[TB] special cases");
      runOp("div0",   3'd4, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1);
      runOp("rem0",   3'd6, 32'd5,        32'd0,        5'd14, 32'd5,        1);
      runOp("divOvf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1);
      runOp("remOvf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        1);

      $display("[TB] flush during divide");
      applyStimulus(3'd5, 32'd1000, 32'd3, 5'd17);
      @(posedge clk);
      #1 i_start = 1'b0;
      repeat (10) @(negedge clk);
      i_flush = 1'b1;
      @(posedge clk);
      #1 i_flush = 1'b0;
      @(negedge clk);
      checkOutput("flush_busy", {31'd0, o_busy}, 32'd0);
      checkOutput("flush_hold", {31'd0, o_hold2ctrl}, 32'd0);
      sawWen = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (o_rd_wen2reg) sawWen = 1;
      end
      checkOutput("flush_noWb", {31'd0, sawWen}, 32'd0);
      runOp("mulAfterFlush", 3'd0, 32'd3, 32'd4, 5'd18, 32'd12, 33);

      $display("[TB] flush in DONE");
      applyStimulus(3'd5, 32'd9, 32'd0, 5'd19);
      @(posedge clk);
      #1 i_start = 1'b0;
      i_flush = 1'b1;
      #1;
      checkOutput("flushDone_wen", {31'd0, o_rd_wen2reg}, 32'd0);
      @(negedge clk);
      i_flush = 1'b0;
      @(negedge clk);
      checkOutput("flushDone_idle", {31'd0, o_busy}, 32'd0);

      $display("[TB] reset mid-operation");
      applyStimulus(3'd0, 32'd11, 32'd13, 5'd20);
      @(posedge clk);
      #1 i_start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("arst_data", o_rd_data, 32'd0);
      checkOutput("arst_addr", {27'd0, o_rd_addr}, 32'd0);
      checkOutput("arst_busy", {31'd0, o_busy}, 32'd0);
      checkOutput("arst_hold", {31'd0, o_hold2ctrl}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      sawWen = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (o_rd_wen2reg) sawWen = 1;
      end
      checkOutput("arst_noWb", {31'd0, sawWen}, 32'd0);

      $display("[TB] start with flush");
      applyStimulus(3'd3, 32'd5, 32'd6, 5'd21);
      i_flush = 1'b1;
      #1;
      checkOutput("startFlush_hold", {31'd0, o_hold2ctrl}, 32'd0);
      @(posedge clk);
      #1 begin
         i_start = 1'b0;
         i_flush = 1'b0;
      end
      @(negedge clk);
      checkOutput("startFlush_busy", {31'd0, o_busy}, 32'd0);
      sawWen = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (o_rd_wen2reg) sawWen = 1;
      end
      checkOutput("startFlush_noWb", {31'd0, sawWen}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
